// File: rtl/ptp_cycle_timer_sm_pkg.sv
// rtl/ptp_cycle_timer_sm_pkg.sv - shared PTP time types, FSM encoding and compare helper
package ptp_cycle_timer_sm_pkg;

    localparam int unsigned NS_PER_SEC = 1_000_000_000;

    typedef struct packed {
        logic [47:0] sec;
        logic [31:0] ns;
    } ptp_time_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CATCHUP    = 2'd1,
        WAIT_START = 2'd2,
        RUNNING    = 2'd3
    } timer_state_t;

    // Seconds decide first; ns only breaks a tie.
    function automatic logic time_ge(input ptp_time_t a, input ptp_time_t b);
        return (a.sec > b.sec) || ((a.sec == b.sec) && (a.ns >= b.ns));
    endfunction

endpackage

// File: rtl/ptp_time_add.sv
// rtl/ptp_time_add.sv - normalizing add of a ns offset to a {sec, ns} PTP time
module ptp_time_add
    import ptp_cycle_timer_sm_pkg::ptp_time_t;
#(
    parameter int unsigned NS_PER_SEC = ptp_cycle_timer_sm_pkg::NS_PER_SEC
) (
    input  ptp_time_t   t,
    input  logic [31:0] add_ns,
    output ptp_time_t   sum
);

    logic [32:0] ns_sum;

    // Both operands are below NS_PER_SEC, so one subtraction always normalizes.
    always_comb begin
        ns_sum = {1'b0, t.ns} + {1'b0, add_ns};
        if (ns_sum >= 33'(NS_PER_SEC)) begin
            sum.ns  = 32'(ns_sum - 33'(NS_PER_SEC));
            sum.sec = t.sec + 48'd1;
        end else begin
            sum.ns  = ns_sum[31:0];
            sum.sec = t.sec;
        end
    end

endmodule

// File: rtl/ptp_cycle_timer_sm.sv
// rtl/ptp_cycle_timer_sm.sv - PTP-aligned gate cycle timer producing CycleStart pulses
module ptp_cycle_timer_sm
    import ptp_cycle_timer_sm_pkg::ptp_time_t, ptp_cycle_timer_sm_pkg::timer_state_t,
           ptp_cycle_timer_sm_pkg::time_ge, ptp_cycle_timer_sm_pkg::IDLE,
           ptp_cycle_timer_sm_pkg::CATCHUP, ptp_cycle_timer_sm_pkg::WAIT_START,
           ptp_cycle_timer_sm_pkg::RUNNING;
#(
    parameter int unsigned CLK_PERIOD_NS = 8,
    parameter int unsigned NS_PER_SEC    = ptp_cycle_timer_sm_pkg::NS_PER_SEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] sync_time_ptp_sec,
    input  logic [31:0] sync_time_ptp_ns,
    input  logic        enable,
    input  logic        cfg_valid,
    input  logic [47:0] base_time_sec,
    input  logic [31:0] base_time_ns,
    input  logic [31:0] cycle_time_ns,
    output logic        CycleStart,
    output logic        cfg_error,
    output logic [15:0] overrun_count,
    output logic [31:0] cycle_count,
    output logic [1:0]  timer_state
);

    localparam logic [31:0] MIN_CYCLE_NS = 32'(2 * CLK_PERIOD_NS);
    localparam logic [31:0] NS_LIMIT     = 32'(NS_PER_SEC);

    timer_state_t state, state_next;
    ptp_time_t    now, next_start, next_plus, cfg_base;
    logic [31:0]  cfg_cycle;
    logic         cfg_ok, enable_d, overrun_mode;
    logic         cfg_in_ok, enable_rise, now_ge_next, now_ge_plus;
    logic         load_cfg, reject_cfg, restart, advance, fire, skip;

    assign now         = {sync_time_ptp_sec, sync_time_ptp_ns};
    assign cfg_in_ok   = (cycle_time_ns >= MIN_CYCLE_NS) && (cycle_time_ns < NS_LIMIT)
                         && (base_time_ns < NS_LIMIT);
    assign enable_rise = enable && !enable_d;
    assign now_ge_next = time_ge(now, next_start);
    assign now_ge_plus = time_ge(now, next_plus);
    assign timer_state = state;

    ptp_time_add #(.NS_PER_SEC(NS_PER_SEC)) u_next_add (
        .t      (next_start),
        .add_ns (cfg_cycle),
        .sum    (next_plus)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cfg_valid) begin
            state_next = (cfg_in_ok && enable) ? CATCHUP : IDLE;
        end else if (!enable) begin
            state_next = IDLE;
        end else if (restart) begin
            state_next = CATCHUP;
        end else begin
            case (state)
                CATCHUP:             if (!now_ge_next) state_next = WAIT_START;
                WAIT_START, RUNNING: if (fire) state_next = now_ge_plus ? CATCHUP : RUNNING;
                default:             state_next = state;
            endcase
        end
    end

    // Holding off a fire right after a pulse keeps CycleStart from ever being back-to-back.
    always_comb begin
        load_cfg   = 1'b0;
        reject_cfg = 1'b0;
        restart    = 1'b0;
        advance    = 1'b0;
        fire       = 1'b0;
        if (cfg_valid) begin
            load_cfg   = cfg_in_ok;
            reject_cfg = !cfg_in_ok;
        end else if (enable) begin
            if (enable_rise && cfg_ok && state == IDLE) begin
                restart = 1'b1;
            end else begin
                case (state)
                    CATCHUP:             advance = now_ge_next;
                    WAIT_START, RUNNING: fire    = now_ge_next && !CycleStart;
                    default:             ;
                endcase
            end
        end
        skip = advance && overrun_mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            CycleStart    <= 1'b0;
            cfg_error     <= 1'b0;
            overrun_count <= '0;
            cycle_count   <= '0;
            next_start    <= '0;
            cfg_base      <= '0;
            cfg_cycle     <= '0;
            cfg_ok        <= 1'b0;
            enable_d      <= 1'b0;
            overrun_mode  <= 1'b0;
        end else begin
            enable_d   <= enable;
            CycleStart <= fire;
            cfg_error  <= reject_cfg;
            if (load_cfg) begin
                cfg_base     <= {base_time_sec, base_time_ns};
                cfg_cycle    <= cycle_time_ns;
                cfg_ok       <= 1'b1;
                next_start   <= {base_time_sec, base_time_ns};
                overrun_mode <= 1'b0;
            end else if (restart) begin
                next_start   <= cfg_base;
                overrun_mode <= 1'b0;
            end else if (advance || fire) begin
                next_start <= next_plus;
            end
            // Catch-up steps only count as overruns when a time jump, not a reload, caused them.
            if (fire) begin
                cycle_count  <= cycle_count + 32'd1;
                overrun_mode <= now_ge_plus;
            end
            if (skip && overrun_count != 16'hFFFF) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end

endmodule
